// File: rtl/openram_seq_ctrl_pkg.sv
// Shared widths, register field offsets and sequencer state encoding for openram_seq_ctrl.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package openram_seq_ctrl_pkg;

    // Select field width: at least one bit even for a single macro.
    function automatic int sel_w(input int num_srams);
        return ($clog2(num_srams) < 1) ? 1 : $clog2(num_srams);
    endfunction

    // One port slice is {addr, din, csb_en, web, wmask}.
    function automatic int port_w(input int addr_w, input int data_w, input int wmask_w);
        return addr_w + data_w + 2 + wmask_w;
    endfunction

    function automatic int total_w(input int num_srams, input int addr_w,
                                   input int data_w, input int wmask_w);
        return sel_w(num_srams) + 2 * port_w(addr_w, data_w, wmask_w);
    endfunction

    // Field offsets inside one port slice, counted from the slice LSB.
    localparam int WMASK_LSB = 0;

    function automatic int web_bit(input int wmask_w);
        return wmask_w;
    endfunction

    function automatic int csb_en_bit(input int wmask_w);
        return wmask_w + 1;
    endfunction

    function automatic int din_lsb(input int wmask_w);
        return wmask_w + 2;
    endfunction

    function automatic int addr_lsb(input int wmask_w, input int data_w);
        return wmask_w + 2 + data_w;
    endfunction

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

endpackage

// File: rtl/openram_seq_ctrl_if.sv
// Shared SRAM macro bus: broadcast addr/din/web/wmask, per-macro csb, flattened dout per port.
// Latency: wires only.
// Backpressure: none; macros are always ready.
// Ports: master = controller side (drives commands, reads dout); slave = macro array side.
interface openram_seq_ctrl_if #(
    parameter int NUM_SRAMS = 16,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int WMASK_W   = 4
);
    logic [ADDR_W-1:0]           addr0;
    logic [DATA_W-1:0]           din0;
    logic                        web0;
    logic [WMASK_W-1:0]          wmask0;
    logic [NUM_SRAMS-1:0]        csb0;
    logic [NUM_SRAMS*DATA_W-1:0] dout0;
    logic [ADDR_W-1:0]           addr1;
    logic [DATA_W-1:0]           din1;
    logic                        web1;
    logic [WMASK_W-1:0]          wmask1;
    logic [NUM_SRAMS-1:0]        csb1;
    logic [NUM_SRAMS*DATA_W-1:0] dout1;

    modport master (
        output addr0, din0, web0, wmask0, csb0,
        output addr1, din1, web1, wmask1, csb1,
        input  dout0, dout1
    );

    modport slave (
        input  addr0, din0, web0, wmask0, csb0,
        input  addr1, din1, web1, wmask1, csb1,
        output dout0, dout1
    );
endinterface

// File: rtl/openram_dout_mux.sv
// Selects one macro's read data out of a flattened NUM_SRAMS*DATA_W bus; out-of-range select gives 0.
// Latency: combinational.
// Backpressure: none.
// Ports: dout (flattened read data, macro i at [i*DATA_W +: DATA_W]), sel, rd_dat (selected word).
module openram_dout_mux #(
    parameter int NUM_SRAMS = 16,
    parameter int DATA_W    = 32,
    parameter int SEL_W     = 4
) (
    input  logic [NUM_SRAMS*DATA_W-1:0] dout,
    input  logic [SEL_W-1:0]            sel,
    output logic [DATA_W-1:0]           rd_dat
);

    always_comb begin
        rd_dat = '0;
        for (int i = 0; i < NUM_SRAMS; i++) begin
            if (int'(sel) == i) begin
                rd_dat = dout[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/openram_seq_ctrl.sv
// Scan/parallel-loadable two-port SRAM command register plus a one-shot access sequencer.
// Latency: start -> one-cycle csb in ISSUE -> capture READ_LAT cycles later -> done pulse next cycle.
// Backpressure: start, scan_en and load_en are ignored while busy; start also loses to scan_en/load_en.
// Ports: clk/reset (sync, active-high); scan_en/scan_in/scan_out serial access; load_en/load_data
//        parallel load; start/busy/done/sel_err status; reg_out register view; sram = macro bus.
//        READ_LAT must be at least 1.
module openram_seq_ctrl
    import openram_seq_ctrl_pkg::*;
#(
    parameter int NUM_SRAMS = 16,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int WMASK_W   = 4,
    parameter int READ_LAT  = 1,
    localparam int TOTAL_W  = total_w(NUM_SRAMS, ADDR_W, DATA_W, WMASK_W)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan_en,
    input  logic               scan_in,
    output logic               scan_out,
    input  logic               load_en,
    input  logic [TOTAL_W-1:0] load_data,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               sel_err,
    output logic [TOTAL_W-1:0] reg_out,
    openram_seq_ctrl_if.master sram
);

    localparam int SEL_W    = sel_w(NUM_SRAMS);
    localparam int PORT_W   = port_w(ADDR_W, DATA_W, WMASK_W);
    localparam int P0_LSB   = PORT_W;
    localparam int P1_LSB   = 0;
    localparam int WEB_B    = web_bit(WMASK_W);
    localparam int CSB_EN_B = csb_en_bit(WMASK_W);
    localparam int DIN_L    = din_lsb(WMASK_W);
    localparam int ADDR_L   = addr_lsb(WMASK_W, DATA_W);
    localparam int CNT_W    = $clog2(READ_LAT + 1);

    logic [TOTAL_W-1:0]   cmd_q;
    logic [SEL_W-1:0]     sel;
    logic [PORT_W-1:0]    p0;
    logic [PORT_W-1:0]    p1;
    logic [DATA_W-1:0]    rd0;
    logic [DATA_W-1:0]    rd1;
    logic [NUM_SRAMS-1:0] csb0_c;
    logic [NUM_SRAMS-1:0] csb1_c;
    logic [CNT_W-1:0]     cnt;
    state_t               state;
    state_t               state_nxt;

    assign sel = cmd_q[TOTAL_W-1 -: SEL_W];
    assign p0  = cmd_q[P0_LSB +: PORT_W];
    assign p1  = cmd_q[P1_LSB +: PORT_W];

    assign sel_err  = (int'(sel) >= NUM_SRAMS);
    assign scan_out = cmd_q[TOTAL_W-1];
    assign reg_out  = cmd_q;

    assign sram.addr0  = p0[ADDR_L +: ADDR_W];
    assign sram.din0   = p0[DIN_L +: DATA_W];
    assign sram.web0   = p0[WEB_B];
    assign sram.wmask0 = p0[WMASK_LSB +: WMASK_W];
    assign sram.csb0   = csb0_c;
    assign sram.addr1  = p1[ADDR_L +: ADDR_W];
    assign sram.din1   = p1[DIN_L +: DATA_W];
    assign sram.web1   = p1[WEB_B];
    assign sram.wmask1 = p1[WMASK_LSB +: WMASK_W];
    assign sram.csb1   = csb1_c;

    openram_dout_mux #(.NUM_SRAMS(NUM_SRAMS), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_mux0 (
        .dout   (sram.dout0),
        .sel    (sel),
        .rd_dat (rd0)
    );

    openram_dout_mux #(.NUM_SRAMS(NUM_SRAMS), .DATA_W(DATA_W), .SEL_W(SEL_W)) u_mux1 (
        .dout   (sram.dout1),
        .sel    (sel),
        .rd_dat (rd1)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT spans READ_LAT-1 cycles: cnt counts 0..READ_LAT-2 inside it.
    always_ff @(posedge clk) begin
        if (reset || state == S_ISSUE) begin
            cnt <= '0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        csb0_c    = '1;
        csb1_c    = '1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && !scan_en && !load_en) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A bad select never reaches the array.
                if (!sel_err) begin
                    csb0_c[sel] = p0[CSB_EN_B];
                    csb1_c[sel] = p1[CSB_EN_B];
                end
                state_nxt = (READ_LAT == 1) ? S_CAPTURE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt == CNT_W'(READ_LAT - 2)) begin
                    state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Host access only in IDLE; the sequencer only ever rewrites din fields of read ports.
    // The mux returns 0 for an out-of-range select, which covers the sel_err capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q <= '0;
        end else if (state == S_IDLE) begin
            if (scan_en) begin
                cmd_q <= {cmd_q[TOTAL_W-2:0], scan_in};
            end else if (load_en) begin
                cmd_q <= load_data;
            end
        end else if (state == S_CAPTURE) begin
            if (!p0[CSB_EN_B] && p0[WEB_B]) begin
                cmd_q[P0_LSB + DIN_L +: DATA_W] <= rd0;
            end
            if (!p1[CSB_EN_B] && p1[WEB_B]) begin
                cmd_q[P1_LSB + DIN_L +: DATA_W] <= rd1;
            end
        end
    end

endmodule

// File: tb/tb_openram_seq_ctrl.sv
// Bench for openram_seq_ctrl: a default build (16 macros, READ_LAT=1) and a 12-macro READ_LAT=3
// build share all command-side stimulus; each is compared against a field-level reference model.
// Ports: both instances fully connected; SRAM dout driven from bench memory arrays.
module tb_openram_seq_ctrl;

    localparam int TW = 112;

    logic          clk = 1'b0;
    logic          reset, scan_en, scan_in, load_en, start;
    logic [TW-1:0] load_data;
    logic          a_scan_out, a_busy, a_done, a_sel_err;
    logic          b_scan_out, b_busy, b_done, b_sel_err;
    logic [TW-1:0] a_reg, b_reg;
    logic [31:0]   mem0 [16];
    logic [31:0]   mem1 [16];
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    openram_seq_ctrl_if #(.NUM_SRAMS(16)) sram_a ();
    openram_seq_ctrl_if #(.NUM_SRAMS(12)) sram_b ();

    openram_seq_ctrl #(.NUM_SRAMS(16), .READ_LAT(1)) dut_a (
        .clk(clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in), .scan_out(a_scan_out),
        .load_en(load_en), .load_data(load_data), .start(start), .busy(a_busy), .done(a_done),
        .sel_err(a_sel_err), .reg_out(a_reg), .sram(sram_a.master)
    );

    openram_seq_ctrl #(.NUM_SRAMS(12), .READ_LAT(3)) dut_b (
        .clk(clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in), .scan_out(b_scan_out),
        .load_en(load_en), .load_data(load_data), .start(start), .busy(b_busy), .done(b_done),
        .sel_err(b_sel_err), .reg_out(b_reg), .sram(sram_b.master)
    );

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sram_a.dout0[i*32 +: 32] = mem0[i];
            sram_a.dout1[i*32 +: 32] = mem1[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 12; i++) begin
            sram_b.dout0[i*32 +: 32] = mem0[i];
            sram_b.dout1[i*32 +: 32] = mem1[i];
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk_cmd(
        input logic [3:0] sel,
        input logic [15:0] a0, input logic [31:0] d0, input logic c0, input logic w0,
        input logic [3:0] m0,
        input logic [15:0] a1, input logic [31:0] d1, input logic c1, input logic w1,
        input logic [3:0] m1);
        return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    // Result register after one sequence: read ports (csb_en=0, web=1) take the selected
    // macro's word, or 0 when the select names no macro; everything else is kept.
    function automatic logic [TW-1:0] exp_reg(input logic [TW-1:0] cmd, input int ns,
                                              input logic [31:0] m0 [16],
                                              input logic [31:0] m1 [16]);
        logic [TW-1:0] r;
        int            s;
        r = cmd;
        s = int'(cmd[111:108]);
        if (!cmd[59] && cmd[58]) r[60 +: 32] = (s < ns) ? m0[s] : 32'h0;
        if (!cmd[5]  && cmd[4])  r[6 +: 32]  = (s < ns) ? m1[s] : 32'h0;
        return r;
    endfunction

    // Chip selects during the issue cycle for the port whose slice starts at base.
    function automatic logic [15:0] exp_csb(input logic [TW-1:0] cmd, input int base, input int ns);
        logic [15:0] c;
        int          s;
        c = 16'hFFFF;
        s = int'(cmd[111:108]);
        if (s < ns && !cmd[base + 5]) c[s] = 1'b0;
        if (ns < 16) c = c & 16'h0FFF;
        return c;
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 16; i++) begin
            mem0[i] = $urandom;
            mem1[i] = $urandom;
        end
    endtask

    // mode 0: plain sequence; 1: scan/load while busy and start in DONE;
    // 2: dout changes around the slow build's capture; 3: reset pulse during WAIT.
    task automatic run_seq(input string nm, input logic [TW-1:0] cmd, input int mode);
        logic [TW-1:0] ea, eb;
        logic [15:0]   ac0, ac1, bc0, bc1;
        logic          a_busy1;
        int            a_low, b_low, a_dn, b_dn, a_at, b_at, s;
        a_low = 0; b_low = 0; a_dn = 0; b_dn = 0; a_at = -1; b_at = -1;
        ac0 = '0; ac1 = '0; bc0 = '0; bc1 = '0; a_busy1 = 1'b0;
        s = int'(cmd[111:108]);

        @(negedge clk);
        load_data = cmd;
        load_en   = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        chk({nm, " load_a"}, 128'(a_reg), 128'(cmd));
        chk({nm, " sel_err_a"}, 128'(a_sel_err), 128'(s >= 16));
        chk({nm, " sel_err_b"}, 128'(b_sel_err), 128'(s >= 12));
        chk({nm, " bus_a"},
            128'({sram_a.addr0, sram_a.din0, sram_a.web0, sram_a.wmask0,
                  sram_a.addr1, sram_a.din1, sram_a.web1, sram_a.wmask1}),
            128'({cmd[107:60], cmd[58:54], cmd[53:6], cmd[4:0]}));
        ea = exp_reg(cmd, 16, mem0, mem1);
        eb = exp_reg(cmd, 12, mem0, mem1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        for (int k = 1; k <= 10; k++) begin
            if (sram_a.csb0 != 16'hFFFF || sram_a.csb1 != 16'hFFFF) a_low++;
            if (sram_b.csb0 != 12'hFFF || sram_b.csb1 != 12'hFFF) b_low++;
            if (k == 1) begin
                ac0 = sram_a.csb0; ac1 = sram_a.csb1;
                bc0 = {4'h0, sram_b.csb0}; bc1 = {4'h0, sram_b.csb1};
                a_busy1 = a_busy;
            end
            if (a_done) begin a_dn++; a_at = k; end
            if (b_done) begin b_dn++; b_at = k; end

            if (mode == 1) begin
                if (k == 1 || k == 2) begin
                    scan_en   = 1'b1;
                    load_en   = 1'b1;
                    scan_in   = 1'($urandom);
                    load_data = {$urandom, $urandom, $urandom, 16'($urandom)};
                end else if (k == 3) begin
                    scan_en = 1'b0;
                    load_en = 1'b0;
                    start   = 1'b1;
                end else begin
                    start = 1'b0;
                end
            end
            if (mode == 2 && k == 4) begin
                fill_mem();
                eb = exp_reg(cmd, 12, mem0, mem1);
            end
            if (mode == 2 && k == 5) fill_mem();
            if (mode == 3 && k == 2) reset = 1'b1;
            if (mode == 3 && k == 3) reset = 1'b0;
            @(negedge clk);
        end
        scan_en = 1'b0; load_en = 1'b0; start = 1'b0; reset = 1'b0;

        if (mode == 3) begin
            chk({nm, " rst_reg_a"}, 128'(a_reg), 128'(0));
            chk({nm, " rst_reg_b"}, 128'(b_reg), 128'(0));
            chk({nm, " rst_done_a"}, 128'(a_dn), 128'(0));
            chk({nm, " rst_done_b"}, 128'(b_dn), 128'(0));
            chk({nm, " rst_busy"}, 128'({a_busy, b_busy}), 128'(0));
            chk({nm, " rst_csb_a"}, 128'({sram_a.csb0, sram_a.csb1}), 128'(32'hFFFF_FFFF));
        end else begin
            chk({nm, " busy_a"}, 128'(a_busy1), 128'(1));
            chk({nm, " csb0_a"}, 128'(ac0), 128'(exp_csb(cmd, 54, 16)));
            chk({nm, " csb1_a"}, 128'(ac1), 128'(exp_csb(cmd, 0, 16)));
            chk({nm, " csb0_b"}, 128'(bc0), 128'(exp_csb(cmd, 54, 12)));
            chk({nm, " csb1_b"}, 128'(bc1), 128'(exp_csb(cmd, 0, 12)));
            chk({nm, " csb_cycles_a"}, 128'(a_low),
                128'((exp_csb(cmd, 54, 16) & exp_csb(cmd, 0, 16)) != 16'hFFFF));
            chk({nm, " csb_cycles_b"}, 128'(b_low),
                128'((exp_csb(cmd, 54, 12) & exp_csb(cmd, 0, 12)) != 16'h0FFF));
            chk({nm, " done_cnt_a"}, 128'(a_dn), 128'(1));
            chk({nm, " done_cnt_b"}, 128'(b_dn), 128'(1));
            chk({nm, " done_at_a"}, 128'(a_at), 128'(3));
            chk({nm, " done_at_b"}, 128'(b_at), 128'(5));
            chk({nm, " result_a"}, 128'(a_reg), 128'(ea));
            chk({nm, " result_b"}, 128'(b_reg), 128'(eb));
            chk({nm, " idle"}, 128'({a_busy, b_busy}), 128'(0));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [TW-1:0] pat, m, cmd;
        reset = 1'b1; scan_en = 1'b0; scan_in = 1'b0; load_en = 1'b0; start = 1'b0;
        load_data = '0;
        for (int i = 0; i < 16; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset_reg", 128'({a_reg, b_reg}), 128'(0));
        chk("reset_flags", 128'({a_busy, a_done, a_scan_out, a_sel_err,
                                 b_busy, b_done, b_scan_out, b_sel_err}), 128'(0));
        chk("reset_csb_a", 128'({sram_a.csb0, sram_a.csb1}), 128'(32'hFFFF_FFFF));
        chk("reset_csb_b", 128'({sram_b.csb0, sram_b.csb1}), 128'(24'hFF_FFFF));

        pat = {14{8'hA5}};
        m   = '0;
        for (int k = 0; k < TW; k++) begin
            chk("scan_out", 128'(a_scan_out), 128'(m[TW-1]));
            scan_in = pat[TW-1-k];
            scan_en = 1'b1;
            m = {m[TW-2:0], scan_in};
            @(negedge clk);
        end
        scan_en = 1'b0;
        chk("scan_reg_a", 128'(a_reg), 128'(pat));
        chk("scan_reg_b", 128'(b_reg), 128'(pat));
        chk("scan_csb_a", 128'({sram_a.csb0, sram_a.csb1}), 128'(32'hFFFF_FFFF));
        chk("scan_busy", 128'({a_busy, b_busy}), 128'(0));

        fill_mem();
        mem0[3] = 32'hDEADBEEF;
        run_seq("rd_sel3", mk_cmd(4'd3, 16'h0010, 32'h0, 1'b0, 1'b1, 4'h0,
                                  16'h0000, 32'h0, 1'b1, 1'b0, 4'h0), 0);
        chk("rd_sel3_din0", 128'(a_reg[60 +: 32]), 128'(32'hDEADBEEF));

        run_seq("wr_rd_sel15", mk_cmd(4'd15, 16'h0100, 32'h12345678, 1'b0, 1'b0, 4'hF,
                                      16'h0200, 32'h0, 1'b0, 1'b1, 4'h0), 0);
        run_seq("rd_sel13", mk_cmd(4'd13, 16'h0ABC, 32'h5555_AAAA, 1'b0, 1'b1, 4'h3,
                                   16'h0DEF, 32'hFFFF_0000, 1'b0, 1'b1, 4'hC), 0);
        run_seq("dout_change", mk_cmd(4'd5, 16'($urandom), $urandom, 1'b0, 1'b1, 4'h0,
                                      16'($urandom), $urandom, 1'b0, 1'b1, 4'h0), 2);
        run_seq("busy_ignore", mk_cmd(4'd7, 16'h0040, 32'h0, 1'b0, 1'b1, 4'h0,
                                      16'h0041, 32'hCAFE_F00D, 1'b1, 1'b1, 4'h1), 1);
        run_seq("reset_wait", mk_cmd(4'd2, 16'h0042, 32'h0, 1'b0, 1'b1, 4'h0,
                                     16'h0043, 32'h0, 1'b0, 1'b1, 4'h0), 3);

        for (int n = 0; n < 24; n++) begin
            fill_mem();
            cmd = {$urandom, $urandom, $urandom, 16'($urandom)};
            run_seq($sformatf("rand%0d", n), cmd, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/openram_seq_ctrl.md
Name: openram_seq_ctrl

Overview:
- Parametrised successor to the OpenRAM testchip control block.
- Holds a scan- and parallel-loadable command register for two SRAM ports (SEL | port0 | port1) and drives shared address/data/control lines to NUM_SRAMS macros.
- Adds an autonomous access sequencer: on start it pulses chip select for exactly one cycle, waits READ_LAT cycles, then captures the selected macro's dout into the register.
- Sits between the LA/GPIO front-end (clock already muxed upstream) and the SRAM macro array.

Parameters:
- NUM_SRAMS, 16, number of SRAM macros; SEL_W = max(1, clog2(NUM_SRAMS)).
- ADDR_W, 16, address width per port.
- DATA_W, 32, data width per port.
- WMASK_W, 4, write-mask width per port.
- READ_LAT, 1, cycles from CSB assertion to valid dout; must be ≥1.
- Derived: PORT_W = ADDR_W+DATA_W+2+WMASK_W; TOTAL_W = SEL_W+2*PORT_W (112 at defaults).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- scan_en  in  1  shift register one bit per cycle
- scan_in  in  1  serial data into register LSB
- scan_out  out  1  register MSB
- load_en  in  1  parallel load from load_data
- load_data  in  TOTAL_W  parallel command word
- start  in  1  launch one access sequence
- busy  out  1  sequencer not IDLE
- done  out  1  one-cycle pulse when capture complete
- sel_err  out  1  SEL ≥ NUM_SRAMS
- reg_out  out  TOTAL_W  command/result register
- addr0/din0/web0/wmask0  out  ADDR_W/DATA_W/1/WMASK_W  port0 shared fields
- csb0  out  NUM_SRAMS  per-macro active-low select, port0
- addr1/din1/web1/wmask1  out  as port0  port1 shared fields
- csb1  out  NUM_SRAMS  per-macro active-low select, port1
- dout0  in  NUM_SRAMS*DATA_W  flattened port0 read data; macro i at [i*DATA_W +: DATA_W]
- dout1  in  NUM_SRAMS*DATA_W  flattened port1 read data

Behaviour:
- Register layout, MSB→LSB: SEL, then per port (port0, then port1): addr, din, csb_en, web, wmask.
- csb_en = 0 means that port participates in the sequence.
- Reset:
  - register = 0, state IDLE.
  - busy = done = 0.
  - csb0 = csb1 = all ones.
  - scan_out = 0.
  - sel_err reflects SEL = 0 (0 unless NUM_SRAMS = 0).
- Register update priority in IDLE: reset > scan_en > load_en > start.
  - scan: reg <= {reg[TOTAL_W-2:0], scan_in}.
  - load: reg <= load_data.
- While busy, scan_en and load_en are ignored and the register holds until CAPTURE.
- start is ignored when busy, or when scan_en or load_en is high in the same cycle.
- FSM: IDLE → ISSUE → WAIT → CAPTURE → DONE → IDLE.
  - start sampled at edge N → ISSUE in cycle N+1.
  - WAIT lasts exactly READ_LAT−1 cycles; skipped when READ_LAT = 1.
  - CAPTURE occurs READ_LAT cycles after ISSUE.
  - DONE lasts one cycle with done = 1.
  - busy = 1 in every state except IDLE.
- csbX:
  - All ones except in ISSUE.
  - In ISSUE, bit SEL is driven to csb_en of that port; all other bits are 1.
  - If sel_err, all bits are 1 in every state.
- addr/din/web/wmask are driven combinationally from the register at all times.
- CAPTURE, per port: if csb_en = 0 and web = 1, the din field <= dout[SEL].
  - Otherwise the field is unchanged.
  - sel_err forces the captured value to 0 on read ports.
- Only din fields change during a sequence; SEL, addr, csb_en, web and wmask are never modified by the sequencer.
- Reset mid-sequence: returns to IDLE immediately, csb all ones, no done pulse.

Decomposition:
- Shared package:
  - SEL_W, PORT_W, TOTAL_W derivation functions.
  - Field offset constants.
  - FSM state enum (IDLE, ISSUE, WAIT, CAPTURE, DONE).
- Sub-module openram_dout_mux: NUM_SRAMS:1 DATA_W mux with out-of-range → 0; instantiated once per port.

Test Plan:
- Reset, then shift 112 scan bits of pattern 0xA5… → reg_out equals the pattern, scan_out echoes the prior MSB each cycle, csb0/csb1 = 0xFFFF.
- Load SEL=3, port0 read addr=0x0010 (csb_en=0, web=1), port1 idle (csb_en=1); pulse start; model dout0[3] = 0xDEADBEEF.
  - Required: csb0 = 0xFFF7 for exactly one cycle, csb1 stays 0xFFFF.
  - done at start+3 cycles; port0 din field = 0xDEADBEEF.
- Port0 write (web=0, din=0x12345678, wmask=0xF) to SEL=15 plus port1 read → csb0 = csb1 = 0x7FFF in ISSUE, port0 din unchanged, port1 din captured.
- With READ_LAT=3 build: start → csb low at cycle 1, capture at cycle 4, done at cycle 5.
  - Change dout at cycle 3: the value present at cycle 4 is the one captured.
- NUM_SRAMS=12 build, SEL=13 → sel_err=1, no csb asserted, read din captured as 0, done still pulses.
- Assert scan_en and load_en while busy; assert start again in DONE; pulse reset during WAIT.
  - Required: register unaffected by scan/load, no second sequence launched.
  - After reset: IDLE, reg = 0, done never asserted.
